uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Stand-alone UART receiver, the receive end of the team's 8-bit UART link. It deserialises the frames produced by the existing transmitter.
- Frame: 1 start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
- Checks framing and parity, then buffers good bytes in a small first-word-fall-through FIFO with a valid/ready read port.
- Used in loopback systems and as the host-side RX of the UART subsystem.

Parameters:
- CLKS_PER_BIT, 10417, clk cycles per bit (100 MHz / 9600 baud); minimum 4.
- PARITY_EN, 1, 1 = parity bit present, 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
- FIFO_DEPTH, 4, byte FIFO depth; power of 2, minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rx  in  1  serial line, idle high, asynchronous to clk.
- rx_data  out  8  FIFO head byte; valid while rx_valid = 1.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accepts head byte.
- frame_err  out  1  1-cycle pulse: stop bit sampled low.
- parity_err  out  1  1-cycle pulse: parity mismatch.
- overrun  out  1  1-cycle pulse: good byte dropped because the FIFO was full.
- busy  out  1  high whenever the state machine is not IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of bytes held.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values:
  - rx_data = 0, rx_valid = 0, all error pulses = 0, busy = 0, fifo_count = 0.
  - Both rx synchroniser flops = 1; state = IDLE; FIFO pointers = 0.
- Reset asserted mid-frame abandons the frame with no flags and no push.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s only.
- A bit counter runs 0..CLKS_PER_BIT-1 and clears on every state change.
- State machine:
  - IDLE: when rx_s = 0, go to START.
  - START: at count = CLKS_PER_BIT/2 - 1 (integer division), sample rx_s.
    - If 1: false start; return to IDLE silently.
    - If 0: go to DATA. This is the mid-bit sample point.
  - DATA: sample rx_s each time count = CLKS_PER_BIT-1.
    - Shift into a shift register LSB first.
    - After 8 samples, go to PARITY if PARITY_EN = 1, else go to STOP.
  - PARITY: sample at count = CLKS_PER_BIT-1.
    - Expected value = XOR of the 8 data bits, XOR PARITY_ODD.
  - STOP: sample at count = CLKS_PER_BIT-1, then apply the first matching rule:
    - stop = 0: frame_err pulses next cycle; byte discarded. Go to BREAK.
    - parity mismatch: parity_err pulses next cycle; byte discarded. Go to IDLE.
    - otherwise, byte is good: push it to the FIFO. Go to IDLE.
  - BREAK: wait until rx_s = 1, then go to IDLE. No new start is detected while the line is held low.
- Latency: a good byte shows rx_valid = 1 and rx_data = byte on the cycle after the stop-sample cycle, provided the FIFO was empty.
- FIFO (first-word fall-through):
  - rx_data always shows the head entry.
  - Pop occurs when rx_valid & rx_ready. rx_ready is ignored while the FIFO is empty.
  - Push while full with no pop: byte dropped; overrun pulses; contents unchanged.
  - Push and pop in the same cycle while full: both happen; fifo_count stays FIFO_DEPTH; no overrun.
  - Push and pop in the same cycle while empty cannot occur (rx_valid = 0).
  - Pointers wrap modulo FIFO_DEPTH; fifo_count saturates at FIFO_DEPTH.
- frame_err, parity_err and overrun are mutually exclusive. Each is high for exactly one cycle per event.

Test Plan:
- Bench settings: CLKS_PER_BIT = 16, PARITY_EN = 1, even parity, FIFO_DEPTH = 4, rx_ready = 1.
- Normal frames: send 0x55 with parity 0, then 0xAA with parity 0 -> rx_valid pulses once per frame, with rx_data = 0x55 then 0xAA. No error pulses. busy falls after each stop sample.
- Parity error: send 0x01 with parity bit 0 -> parity_err pulses once, no push, fifo_count stays 0.
- Framing error: send 0x3C with correct parity, stop bit 0, line held low 40 cycles, then high -> frame_err pulses once. busy stays high until rx returns high. A following good 0x3C frame is received correctly.
- False start: 4-cycle low glitch on idle rx -> returns to IDLE, no pulses, fifo_count = 0.
- Full FIFO: rx_ready = 0, send 0x11, 0x22, 0x33, 0x44, 0x55 -> fifo_count = 4 and overrun pulses on 0x55. Then raise rx_ready -> reads return 0x11, 0x22, 0x33, 0x44 in order.
- Reset mid-frame: assert rst during DATA bit 3 of a 0xF0 frame -> all outputs 0 next cycle. A following 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8-bit UART receiver with framing/parity checks
// and a small first-word-fall-through byte FIFO on the read side.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 10417,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit PARITY_ODD   = 1'b0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic          rx_meta;
    logic          rx_s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par_bit;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          stop_hit;
    logic          exp_par;
    logic          frame_bad;
    logic          par_bad;
    logic          good;
    logic          full;
    logic          pop;
    logic          push;

    // Two-flop synchroniser; the line idles high, so reset to 1
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame state machine with per-bit counter, cleared on each state change
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == CNT_MID) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= PARITY_EN ? S_PARITY : S_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Stop-sample verdict: framing beats parity, parity beats a push
    always_comb begin
        stop_hit  = (state == S_STOP) && (cnt == CNT_LAST);
        exp_par   = (^shreg) ^ PARITY_ODD;
        frame_bad = stop_hit && !rx_s;
        par_bad   = stop_hit && rx_s && PARITY_EN && (par_bit != exp_par);
        good      = stop_hit && rx_s && !par_bad;
        full      = (count == CNT_FULL);
        pop       = rx_valid && rx_ready;
        push      = good && (!full || pop);
    end

    // Error pulses, registered so each event is one clean cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= frame_bad;
            parity_err <= par_bad;
            overrun    <= good && full && !pop;
        end
    end

    // Storage array is not reset; validity comes from the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shreg;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rx_valid   = (count != '0);
    assign rx_data    = rx_valid ? mem[rd_ptr] : 8'h00;
    assign busy       = (state != S_IDLE);
    assign fifo_count = count;

endmodule
